// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        HALTED = 2'b10
    } seq_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_TIMEOUT  = 2'b10
    } trap_cause_e;

    localparam int unsigned INSN_BYTES = 4;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive unready fetch cycles; flags the cycle in which one
// more unready cycle must become a timeout trap.
module fetch_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    // NOTE: assign a default before any branch so no path leaves the
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (inc) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its input from before the edge, regardless of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired = (wait_cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Fetch controller: chooses what pc_register loads each cycle and
// sequences fetch against a wait-stating instruction memory.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          TIMEOUT     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic        commit,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] epc,
    output logic        halted
);

    seq_state_e  state_q, state_d;
    trap_cause_e cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        cnt_inc;
    logic        cnt_clear;
    logic        cnt_expired;

    logic        redirect;
    logic [31:0] redirect_tgt;
    logic [31:0] seq_pc;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .inc     (cnt_inc),
        .clear   (cnt_clear),
        .expired (cnt_expired)
    );

    // A jump outranks a taken branch, so only the jump target is checked for alignment when both fire.
    assign redirect     = jump | branch_taken;
    assign redirect_tgt = jump ? jump_target : branch_target;
    assign seq_pc       = pc + 32'(INSN_BYTES);

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        next_pc   = pc;
        imem_req  = 1'b0;
        commit    = 1'b0;
        trap      = 1'b0;
        halted    = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clear = 1'b0;

        if (reset) begin
            next_pc = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                end

                FETCH: begin
                    if (!stall) begin
                        imem_req = 1'b1;
                        if (!imem_ready) begin
                            if (cnt_expired) begin
                                trap      = 1'b1;
                                next_pc   = TRAP_VECTOR;
                                epc_d     = pc;
                                cause_d   = CAUSE_TIMEOUT;
                                cnt_clear = 1'b1;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end else begin
                            cnt_clear = 1'b1;
                            if (redirect && is_misaligned(redirect_tgt)) begin
                                trap    = 1'b1;
                                next_pc = TRAP_VECTOR;
                                epc_d   = pc;
                                cause_d = CAUSE_MISALIGN;
                            end else begin
                                commit = 1'b1;
                                if (halt) begin
                                    next_pc = seq_pc;
                                    state_d = HALTED;
                                end else if (redirect) begin
                                    next_pc = redirect_tgt;
                                end else begin
                                    next_pc = seq_pc;
                                end
                            end
                        end
                    end
                end

                HALTED: begin
                    halted = 1'b1;
                    if (resume) begin
                        state_d = FETCH;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign trap_cause = cause_q;
    assign epc        = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed fetch scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural sequencer model.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int          TMO      = 16;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_HALT  = 2;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    logic        commit;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] epc;
    logic        halted;

    int n_vec;
    int n_err;

    // Reference model state
    int          m_mode;
    int          m_waits;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [1:0]  m_cause;

    // Model outputs for the current cycle and its next state
    logic [31:0] e_next;
    logic        e_req, e_commit, e_trap, e_halted;
    int          n_mode, n_waits;
    logic [31:0] n_epc;
    logic [1:0]  n_cause;

    pc_sequencer #(
        .TRAP_VECTOR (TRAP_VEC),
        .TIMEOUT     (TMO)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .next_pc       (next_pc),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .resume        (resume),
        .commit        (commit),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .epc           (epc),
        .halted        (halted)
    );

    // Stand-in for pc_register
    always_ff @(posedge clock) pc <= next_pc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        logic [31:0] tgt;
        logic        redir;
        e_next   = m_pc;
        e_req    = 1'b0;
        e_commit = 1'b0;
        e_trap   = 1'b0;
        e_halted = 1'b0;
        n_mode   = m_mode;
        n_waits  = m_waits;
        n_epc    = m_epc;
        n_cause  = m_cause;
        redir    = jump || branch_taken;
        tgt      = jump ? jump_target : branch_target;
        if (reset) begin
            e_next  = 32'd0;
            n_mode  = M_IDLE;
            n_waits = 0;
            n_epc   = 32'd0;
            n_cause = 2'd0;
        end else if (m_mode == M_IDLE) begin
            n_mode = M_FETCH;
        end else if (m_mode == M_HALT) begin
            e_halted = 1'b1;
            if (resume) n_mode = M_FETCH;
        end else if (!stall) begin
            e_req = 1'b1;
            if (!imem_ready) begin
                if (m_waits + 1 == TMO) begin
                    e_trap  = 1'b1;
                    e_next  = TRAP_VEC;
                    n_epc   = m_pc;
                    n_cause = 2'd2;
                    n_waits = 0;
                end else begin
                    n_waits = m_waits + 1;
                end
            end else begin
                n_waits = 0;
                if (redir && (tgt % 4 != 0)) begin
                    e_trap  = 1'b1;
                    e_next  = TRAP_VEC;
                    n_epc   = m_pc;
                    n_cause = 2'd1;
                end else begin
                    e_commit = 1'b1;
                    if (halt) begin
                        e_next = m_pc + 32'd4;
                        n_mode = M_HALT;
                    end else if (redir) begin
                        e_next = tgt;
                    end else begin
                        e_next = m_pc + 32'd4;
                    end
                end
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model at the edge, then
    // leave the caller 1 ns after the edge to drive the next inputs.
    task automatic step();
        @(negedge clock);
        model_eval();
        check("pc",         pc,         m_pc);
        check("next_pc",    next_pc,    e_next);
        check("imem_req",   imem_req,   e_req);
        check("commit",     commit,     e_commit);
        check("trap",       trap,       e_trap);
        check("halted",     halted,     e_halted);
        check("epc",        epc,        m_epc);
        check("trap_cause", trap_cause, m_cause);
        @(posedge clock);
        m_pc    = e_next;
        m_mode  = n_mode;
        m_waits = n_waits;
        m_epc   = n_epc;
        m_cause = n_cause;
        #1;
    endtask

    task automatic quiet_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;
        halt          = 1'b0;
        resume        = 1'b0;
        imem_ready    = 1'b1;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        quiet_inputs();
        jump        = 1'b1;
        jump_target = addr;
        step();
        quiet_inputs();
        check("goto_pc", pc, addr);
    endtask

    // Hold imem_ready low; stall for stall_len cycles after stall_at unready cycles.
    task automatic run_timeout(input string tag, input logic [31:0] start_pc,
                               input int stall_at, input int stall_len);
        int unready;
        int cycles;
        unready = 0;
        cycles  = 0;
        quiet_inputs();
        imem_ready = 1'b0;
        while (unready < TMO && cycles < 100) begin
            stall = (unready == stall_at && stall_len > 0 && cycles < stall_at + stall_len) ? 1'b1 : 1'b0;
            #1;
            if (!stall) begin
                unready++;
                check({tag, "_trap"}, {31'd0, trap}, (unready == TMO) ? 32'd1 : 32'd0);
            end
            step();
            cycles++;
        end
        check({tag, "_cycles"}, cycles, TMO + stall_len);
        check({tag, "_pc"}, pc, TRAP_VEC);
        check({tag, "_epc"}, epc, start_pc);
        check({tag, "_cause"}, {30'd0, trap_cause}, 32'd2);
        quiet_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        quiet_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        m_mode  = M_IDLE;
        m_waits = 0;
        m_pc    = 32'd0;
        m_epc   = 32'd0;
        m_cause = 2'd0;

        // Reset state, then straight-line fetch 0, 0, 4, 8
        step();
        check("rst_next_pc", next_pc, 32'd0);
        reset = 1'b0;
        check("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check("first_fetch_pc", pc, 32'd0);
        check("first_commit", {31'd0, commit}, 32'd1);
        step();
        check("seq_pc4", pc, 32'd4);
        step();
        check("seq_pc8", pc, 32'd8);

        // Jump beats a simultaneous branch
        jump          = 1'b1;
        jump_target   = 32'h40;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        step();
        quiet_inputs();
        check("jump_prio", pc, 32'h40);

        // Misaligned branch target traps
        goto_pc(32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h22;
        #1;
        check("mis_trap", {31'd0, trap}, 32'd1);
        check("mis_commit", {31'd0, commit}, 32'd0);
        step();
        quiet_inputs();
        check("mis_pc", pc, TRAP_VEC);
        check("mis_epc", epc, 32'h10);
        check("mis_cause", {30'd0, trap_cause}, 32'd1);

        // Timeout without and with a 3-cycle stall mid-wait
        goto_pc(32'h4);
        run_timeout("tmo", 32'h4, -1, 0);
        goto_pc(32'h4);
        run_timeout("tmo_stall", 32'h4, 7, 3);

        // Halt at 0xC, hold, resume
        goto_pc(32'hC);
        halt = 1'b1;
        #1;
        check("halt_commit", {31'd0, commit}, 32'd1);
        step();
        halt  = 1'b0;
        stall = 1'b1;
        check("halt_pc", pc, 32'h10);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        step();
        step();
        check("halt_hold", pc, 32'h10);
        quiet_inputs();
        resume = 1'b1;
        step();
        resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        step();
        check("resume_pc", pc, 32'h14);

        // PC wraps modulo 2^32
        goto_pc(32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc, 32'd0);

        // Reset mid-wait clears state; a fresh timeout then needs full TMO cycles
        goto_pc(32'h8);
        imem_ready = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_pc", pc, 32'd0);
        check("mrst_epc", epc, 32'd0);
        check("mrst_cause", {30'd0, trap_cause}, 32'd0);
        check("mrst_halted", {31'd0, halted}, 32'd0);
        step();
        run_timeout("tmo_after_rst", 32'd0, -1, 0);

        // Randomized traffic, alternating fast and slow memory phases
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] t;
            logic        slow;
            slow          = ((i / 250) % 2) == 1;
            reset         = ($urandom_range(0, 299) == 0);
            imem_ready    = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0);
            stall         = ($urandom_range(0, 7) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            halt          = ($urandom_range(0, 39) == 0);
            resume        = ($urandom_range(0, 3) == 0);
            t             = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            jump_target   = t;
            t             = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            branch_target = t;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch controller for the single-cycle datapath: each cycle it decides what the PC register loads, and it sequences instruction fetch against a memory that may insert wait states. It selects the sequential, branch or jump target and can hold the PC for stalls, memory waits and halt. It also raises traps for misaligned targets and fetch timeouts, recording the faulting PC. It sits between the control/branch unit, the instruction memory and `pc_register`, whose `next_pc` input it drives directly.

## Interface
- `TRAP_VECTOR`, 32'h0000_0100, PC loaded on any trap.
- `TIMEOUT`, 16, maximum consecutive unready fetch cycles before a timeout trap; ≥2.
- `clock` in 1, single clock, rising edge.
- `reset` in 1, synchronous, active-high.
- `pc` in 32, current PC from `pc_register`.
- `next_pc` out 32, value `pc_register` loads at the next edge.
- `imem_req` out 1, fetch request for the instruction at `pc`.
- `imem_ready` in 1, instruction at `pc` is valid this cycle.
- `stall` in 1, hazard stall; freeze fetch.
- `branch_taken` in 1, conditional branch resolved taken.
- `branch_target` in 32, branch destination.
- `jump` in 1, unconditional jump.
- `jump_target` in 32, jump destination.
- `halt` in 1, current instruction is a halt.
- `resume` in 1, leave HALTED.
- `commit` out 1, instruction at `pc` retires this cycle.
- `trap` out 1, trap taken this cycle.
- `trap_cause` out 2, last trap cause: 00 none, 01 misaligned target, 10 fetch timeout.
- `epc` out 32, PC of the last trapping instruction.
- `halted` out 1, sequencer is in HALTED.

## Operation
- States: IDLE, FETCH, HALTED.
- Registered: state, `epc`, `trap_cause`, `wait_cnt`.
- Combinational: `next_pc`, `imem_req`, `commit`, `trap`, `halted`.
- Reset: state=IDLE, `epc`=0, `trap_cause`=00, `wait_cnt`=0, `next_pc`=0. Reset overrides every other input and wins over any in-flight fetch.
- IDLE: `next_pc`=`pc`, `imem_req`=0. Go to FETCH next cycle.
- FETCH with `stall`=1: `next_pc`=`pc`, `imem_req`=0. `imem_ready` is ignored and `wait_cnt` holds.
- FETCH with `stall`=0 and `imem_ready`=0: `imem_req`=1, `next_pc`=`pc`, `wait_cnt`+1.
  - If `wait_cnt`==`TIMEOUT`-1, take a timeout trap instead: `next_pc`=`TRAP_VECTOR`, `trap`=1, `epc`←`pc`, `trap_cause`←10, `wait_cnt`←0.
- FETCH with `stall`=0 and `imem_ready`=1: `imem_req`=1 and `wait_cnt`←0. Resolve in this priority order:
  1. Misaligned target (jump target if `jump`, else branch target if `branch_taken`, with [1:0]≠0): `trap`=1, `commit`=0, `next_pc`=`TRAP_VECTOR`, `epc`←`pc`, `trap_cause`←01.
  2. `halt`: `commit`=1, `next_pc`=`pc`+4, go to HALTED.
  3. `jump`: `commit`=1, `next_pc`=`jump_target`.
  4. `branch_taken`: `commit`=1, `next_pc`=`branch_target`.
  5. Otherwise: `commit`=1, `next_pc`=`pc`+4.
- HALTED: `halted`=1, `imem_req`=0, `next_pc`=`pc`. `resume` moves to FETCH next cycle; `stall` has no effect.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No trap on wrap.
- `trap_cause`/`epc` hold until the next trap or reset. A new trap overwrites them.

## Timing
- `next_pc` is combinational from state, `pc` and inputs. The redirect is visible in `pc` one edge later.
- `commit` and `trap` are single-cycle, same-cycle pulses and mutually exclusive.
- After reset deasserts: one IDLE cycle, then `imem_req`=1 from the second cycle.
- Timeout fires in the `TIMEOUT`th consecutive unready, unstalled FETCH cycle. Stalled cycles neither count nor reset the count.
- `halted` rises the cycle after the halt commit and falls the cycle after `resume`.

## Structure
- Package `pc_seq_pkg`: state enum (IDLE/FETCH/HALTED), cause codes (CAUSE_NONE/MISALIGN/TIMEOUT), `INSN_BYTES`=4.
- One sub-module, `fetch_timeout_counter`, with inputs inc/clear and output `expired` (`wait_cnt`==`TIMEOUT`-1).
- Instantiated next to `pc_register` in the datapath top; `pc_register` is unchanged.

## Test plan
- Reset then `imem_ready`=1 constantly: `pc` sequence 0, 0, 4, 8, 0xC; `commit` high from cycle 2.
- At `pc`=8, `jump`=1 with `jump_target`=0x40: `pc`=0x40 next cycle. With `branch_taken`=1 and `branch_target`=0x20 also asserted in that cycle, `pc` still goes to 0x40.
- At `pc`=0x10, `branch_taken`=1 with `branch_target`=0x22: `trap`=1, `commit`=0, `pc`→0x100, `epc`=0x10, `trap_cause`=01.
- `imem_ready` held 0 at `pc`=4 with `TIMEOUT`=16: `trap` on the 16th cycle, `pc`→0x100, `epc`=4, `trap_cause`=10. A 3-cycle `stall` inserted mid-wait delays the trap by exactly 3 cycles.
- `halt` at `pc`=0x0C: `commit`=1, `pc`=0x10 and then held with `halted`=1 and `imem_req`=0. `resume` pulse → fetch continues at 0x10, 0x14.
- `reset` asserted mid-wait (`wait_cnt`=5): next cycle state=IDLE, `pc`=0, `epc`/`trap_cause` cleared. After release, a timeout needs a full 16 cycles.
